// File: rtl/cim_pkg.sv
// Shared definitions for the compute-in-memory macro: array geometry,
// address field positions and the command encoding used by the core decoder.
package cim_pkg;

    localparam int CIM_NCOL = 16;
    localparam int CIM_NROW = 64;

    localparam int COL_LSB = 8;
    localparam int COL_W   = 4;
    localparam int ROW_LSB = 2;
    localparam int ROW_W   = 6;

    typedef enum logic [2:0] {
        CMD_WR        = 3'b000,
        CMD_COMP      = 3'b001,
        CMD_RD        = 3'b010,
        CMD_REG_RD    = 3'b011,
        CMD_REG_RESET = 3'b100
    } cmd_e;

    // write outranks every cim strobe; clear outranks compute.
    function automatic cmd_e cim_decode(input logic write, input logic cim,
                                        input logic partial_sum, input logic reset_output);
        if (write)                    return CMD_WR;
        else if (cim && reset_output) return CMD_REG_RESET;
        else if (cim && partial_sum)  return CMD_COMP;
        else if (cim)                 return CMD_REG_RD;
        else                          return CMD_RD;
    endfunction

endpackage

// File: rtl/cim_dot4.sv
// Signed 4-lane int8 dot product; each lane product is 16 bits and the
// lane sum is formed in 32 bits so it never overflows.
module cim_dot4 (
    input  logic [31:0] w,
    input  logic [31:0] a,
    output logic [31:0] dot
);

    logic signed [15:0] prod [4];

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign prod[k] = 16'($signed(w[8*k +: 8])) * 16'($signed(a[8*k +: 8]));
    end

    assign dot = 32'(prod[0]) + 32'(prod[1]) + 32'(prod[2]) + 32'(prod[3]);

endmodule

// File: rtl/cim_macro.sv
// Compute-in-memory macro: NCOL x NROW int8x4 weight array, NCOL 32-bit
// accumulators, and a two-stage accept/retire compute pipeline with forwarding.
module cim_macro
    import cim_pkg::*;
#(
    parameter int NCOL = CIM_NCOL,
    parameter int NROW = CIM_NROW
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        write,
    input  logic        cim,
    input  logic        partial_sum,
    input  logic        reset_output,
    input  logic [3:0]  output_reg,
    input  logic [31:0] address,
    input  logic [31:0] input_data,
    output logic [31:0] cim_output
);

    // Commands are single-cycle strobes, acted on at the next rising edge;
    // there is no ready, so a new command may be issued every cycle.
    cmd_e             cmd;
    logic [COL_W-1:0] col_idx;
    logic [ROW_W-1:0] row_idx;
    logic             col_in_range;
    logic             reg_in_range;
    logic             unused_addr;

    assign cmd          = cim_decode(write, cim, partial_sum, reset_output);
    assign col_idx      = address[COL_LSB +: COL_W];
    assign row_idx      = address[ROW_LSB +: ROW_W];
    assign col_in_range = int'(col_idx) < NCOL;
    assign reg_in_range = int'(output_reg) < NCOL;
    assign unused_addr  = ^{address[31:COL_LSB+COL_W], address[ROW_LSB-1:0]};

    logic [31:0]      w_mem [NCOL][NROW];
    logic [31:0]      acc [NCOL];
    logic             pend_v;
    logic [ROW_W-1:0] pend_row;
    logic [31:0]      pend_act;
    logic [31:0]      col_dot [NCOL];
    logic [31:0]      fwd_w;
    logic [31:0]      fwd_dot;

    for (genvar c = 0; c < NCOL; c++) begin : g_col
        cim_dot4 u_dot (
            .w   (w_mem[c][pend_row]),
            .a   (pend_act),
            .dot (col_dot[c])
        );
    end

    always_comb begin
        fwd_w = '0;
        if (reg_in_range) fwd_w = w_mem[output_reg][pend_row];
    end

    cim_dot4 u_fwd (
        .w   (fwd_w),
        .a   (pend_act),
        .dot (fwd_dot)
    );

    // Weight memory is deliberately outside the reset domain.
    always_ff @(posedge CLK) begin
        if (!RES && cmd == CMD_WR && col_in_range)
            w_mem[col_idx][row_idx] <= input_data;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            pend_v <= 1'b0;
            for (int c = 0; c < NCOL; c++) acc[c] <= '0;
        end else begin
            pend_v <= (cmd == CMD_COMP);
            if (cmd == CMD_COMP) begin
                pend_row <= row_idx;
                pend_act <= input_data;
            end
            // A clear wins over a retiring compute, which is then dropped.
            if (cmd == CMD_REG_RESET) begin
                for (int c = 0; c < NCOL; c++) acc[c] <= '0;
            end else if (pend_v) begin
                for (int c = 0; c < NCOL; c++) acc[c] <= acc[c] + col_dot[c];
            end
        end
    end

    always_comb begin
        cim_output = '0;
        case (cmd)
            CMD_RD: begin
                if (col_in_range) cim_output = w_mem[col_idx][row_idx];
            end
            CMD_REG_RD: begin
                if (reg_in_range)
                    cim_output = acc[output_reg] + (pend_v ? fwd_dot : 32'd0);
            end
            default: cim_output = '0;
        endcase
    end

endmodule

// File: tb/tb_cim_macro.sv
// Directed bench for cim_macro: one table of per-cycle commands with
// hand-computed read values, then hand-built clear/forwarding/reset sequences.
module tb_cim_macro;

    logic        CLK = 1'b0;
    logic        RES;
    logic        write;
    logic        cim;
    logic        partial_sum;
    logic        reset_output;
    logic [3:0]  output_reg;
    logic [31:0] address;
    logic [31:0] input_data;
    logic [31:0] cim_output;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic        wr;
        logic        cm;
        logic        ps;
        logic        ro;
        logic [3:0]  oreg;
        logic [31:0] addr;
        logic [31:0] data;
        logic        chk;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    cim_macro dut (
        .CLK          (CLK),
        .RES          (RES),
        .write        (write),
        .cim          (cim),
        .partial_sum  (partial_sum),
        .reset_output (reset_output),
        .output_reg   (output_reg),
        .address      (address),
        .input_data   (input_data),
        .cim_output   (cim_output)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t v_wr(input logic [31:0] addr, input logic [31:0] data);
        vec_t v = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, addr, data, 1'b0, 32'd0, "wr"};
        return v;
    endfunction

    function automatic vec_t v_rd(input logic [31:0] addr, input logic [31:0] exp, input string name);
        vec_t v = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, addr, 32'd0, 1'b1, exp, name};
        return v;
    endfunction

    function automatic vec_t v_comp(input logic [31:0] addr, input logic [31:0] act);
        vec_t v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, addr, act, 1'b0, 32'd0, "comp"};
        return v;
    endfunction

    function automatic vec_t v_clr();
        vec_t v = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0, 1'b0, 32'd0, "clr"};
        return v;
    endfunction

    function automatic vec_t v_rr(input logic [3:0] oreg, input logic [31:0] exp, input string name);
        vec_t v = '{1'b0, 1'b1, 1'b0, 1'b0, oreg, 32'd0, 32'd0, 1'b1, exp, name};
        return v;
    endfunction

    // Drive one cycle's command just after the edge, check mid-cycle.
    task automatic apply(input vec_t v, input logic rst);
        RES          = rst;
        write        = v.wr;
        cim          = v.cm;
        partial_sum  = v.ps;
        reset_output = v.ro;
        output_reg   = v.oreg;
        address      = v.addr;
        input_data   = v.data;
        #4;
        if (v.chk) begin
            n_vec++;
            if (cim_output !== v.exp) begin
                n_fail++;
                $display("FAIL %s: cim_output=0x%08h expected 0x%08h", v.name, cim_output, v.exp);
            end
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        vec_t v;

        v = v_rr(4'd0, 32'd0, "idle");
        v.chk = 1'b0;
        apply(v, 1'b1);
        apply(v_rr(4'd0, 32'd0, "reset_acc0"), 1'b1);
        apply(v_rr(4'd9, 32'd0, "reset_acc9"), 1'b0);

        for (int c = 0; c < 16; c++)
            for (int r = 0; r < 8; r++)
                apply(v_wr(32'((c << 8) | (r << 2)), 32'd0), 1'b0);

        // Weight write/read, forwarded read, signed lanes and wrap.
        tbl.push_back(v_wr(32'h000, 32'h01020304));
        tbl.push_back(v_rd(32'h000, 32'h01020304, "wr_rd_c0r0"));
        tbl.push_back(v_comp(32'h000, 32'h01010101));
        tbl.push_back(v_rr(4'd0, 32'd10, "fwd_acc0"));
        tbl.push_back(v_rr(4'd0, 32'd10, "acc0_after"));
        tbl.push_back(v_wr(32'h10C, 32'hFF02FE01));
        tbl.push_back(v_rd(32'h10C, 32'hFF02FE01, "wr_rd_c1r3"));
        tbl.push_back(v_comp(32'h00C, 32'h04030201));
        tbl.push_back(v_rr(4'd1, 32'hFFFFFFFF, "fwd_signed_acc1"));
        tbl.push_back(v_rr(4'd0, 32'd10, "acc0_zero_row"));
        v = v_clr();
        v.ps = 1'b1;
        tbl.push_back(v);
        tbl.push_back(v_rr(4'd1, 32'd0, "clr_over_comp"));
        tbl.push_back(v_wr(32'h000, 32'h80808080));
        tbl.push_back(v_comp(32'h000, 32'h7F7F7F7F));
        tbl.push_back(v_comp(32'h000, 32'h7F7F7F7F));
        tbl.push_back(v_comp(32'h000, 32'h7F7F7F7F));
        tbl.push_back(v_rr(4'd0, 32'hFFFD0600, "b2b_fwd"));
        tbl.push_back(v_rr(4'd0, 32'hFFFD0600, "b2b_final"));
        v = v_wr(32'h000, 32'h01020304);
        v.cm = 1'b1;
        v.ps = 1'b1;
        tbl.push_back(v);
        tbl.push_back(v_rr(4'd0, 32'hFFFD0600, "wr_masks_comp"));
        tbl.push_back(v_rd(32'hFFFFF003, 32'h01020304, "ignored_addr_bits"));

        foreach (tbl[i]) apply(tbl[i], 1'b0);

        // Compute retiring under a clear is discarded.
        apply(v_comp(32'h000, 32'h01010101), 1'b0);
        apply(v_clr(), 1'b0);
        for (int r = 0; r < 16; r++)
            apply(v_rr(4'(r), 32'd0, $sformatf("clr_acc%0d", r)), 1'b0);

        // A write in the retire cycle must not affect the pending compute.
        apply(v_wr(32'h014, 32'h01010101), 1'b0);
        apply(v_comp(32'h014, 32'h02020202), 1'b0);
        apply(v_wr(32'h014, 32'h00000000), 1'b0);
        apply(v_rr(4'd0, 32'd8, "old_weights"), 1'b0);
        apply(v_comp(32'h014, 32'h02020202), 1'b0);
        apply(v_rr(4'd0, 32'd8, "new_weights_fwd"), 1'b0);
        apply(v_rr(4'd0, 32'd8, "new_weights"), 1'b0);
        apply(v_rd(32'h014, 32'd0, "rd_c0r5"), 1'b0);

        // Reset mid-sequence: pending and same-cycle compute lost, writes ignored.
        apply(v_comp(32'h000, 32'h01010101), 1'b0);
        apply(v_comp(32'h000, 32'h01010101), 1'b1);
        apply(v_wr(32'h014, 32'hDEADBEEF), 1'b1);
        apply(v_rr(4'd0, 32'd0, "post_res_acc0"), 1'b0);
        apply(v_rr(4'd1, 32'd0, "post_res_acc1"), 1'b0);
        apply(v_rd(32'h000, 32'h01020304, "keep_c0r0"), 1'b0);
        apply(v_rd(32'h10C, 32'hFF02FE01, "keep_c1r3"), 1'b0);
        apply(v_rd(32'h014, 32'd0, "res_blocks_wr"), 1'b0);
        apply(v_comp(32'h000, 32'h01010101), 1'b0);
        apply(v_rr(4'd0, 32'd10, "comp_after_res"), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cim_macro.md
CIM_MACRO -- requirements
Module: cim_macro

Interface
REQ-001 SHALL take parameter NCOL, default 16: number of output columns and accumulators.
REQ-002 SHALL take parameter NROW, default 64: weight rows per column; each row is one 32-bit word holding four signed int8 weights.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RES, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port write, input, 1 bit: weight-write strobe.
REQ-006 SHALL have port cim, input, 1 bit: CIM command strobe (compute, register read or register reset).
REQ-007 SHALL have port partial_sum, input, 1 bit: when cim=1, selects compute-and-accumulate.
REQ-008 SHALL have port reset_output, input, 1 bit: when cim=1, selects clear of all accumulators.
REQ-009 SHALL have port output_reg, input, 4 bits: accumulator index for register read.
REQ-010 SHALL have port address, input, 32 bits: byte address; bits [11:8] = column, bits [7:2] = row; all other bits ignored.
REQ-011 SHALL have port input_data, input, 32 bits: write data, or four int8 activations for compute (lane k = bits [8k+7:8k]).
REQ-012 SHALL have port cim_output, output, 32 bits: read data, combinational, sampled by the core in the same cycle.

Function
REQ-013 Command decode SHALL use this priority: write=1 is a weight write; else cim&reset_output is CLEAR; else cim&partial_sum is COMP; else cim=1 is REG_RD; else (all strobes low) is a weight read.
REQ-014 A weight write SHALL store input_data into W[address[11:8]][address[7:2]] at the clock edge; cim strobes in the same cycle SHALL be ignored.
REQ-015 cim_output SHALL be W[address[11:8]][address[7:2]] for weight reads, and acc[output_reg] as defined in REQ-019 for REG_RD.
REQ-016 COMP SHALL be a 2-stage pipeline. Accept cycle N: latch row=address[7:2] and input_data into the pending register, and set pend_v=1.
REQ-017 In cycle N+1, every column c SHALL compute acc[c] += sum over k=0..3 of (W[c][row].byte[k] * act.byte[k]). Products are signed 8x8 to 16-bit, the sum is sign-extended to 32 bits, and accumulation wraps modulo 2^32. pend_v SHALL clear unless a new COMP is accepted in the same cycle.
REQ-018 Back-to-back COMP SHALL sustain one per cycle with no stall output; the block never back-pressures.
REQ-019 REG_RD while pend_v=1 SHALL return the forwarded value acc[output_reg] + dot(pending act, W[output_reg][pending row]), i.e. the value after all earlier commands.
REQ-020 Pending compute SHALL use weights as of cycle N+1 before the edge; a write in cycle N+1 to the same row SHALL NOT affect that compute.
REQ-021 CLEAR SHALL zero all accumulators at the edge. A pending compute retiring in the same cycle SHALL be discarded, giving a result of 0.
REQ-022 output_reg values >= NCOL SHALL read 0.
REQ-023 Accumulators SHALL change only through COMP retirement, CLEAR or RES.

Reset
REQ-024 While RES=1, the block SHALL set all accumulators to 0, set pend_v=0, and ignore all commands.
REQ-025 Weight memory SHALL NOT be cleared by RES.
REQ-026 A COMP accepted in the cycle RES rises SHALL be lost.
REQ-027 cim_output SHALL follow REQ-015 during reset; REG_RD therefore returns 0 from the first cycle after reset.

Structure
REQ-028 A shared package cim_pkg SHALL hold NCOL and NROW defaults, the address field positions, and the command encodings (WR=000, COMP=001, RD=010, REG_RD=011, REG_RESET=100) shared with the core decoder.
REQ-029 A sub-module cim_dot4 SHALL implement the combinational signed 4-lane int8 dot product to 32 bits.
REQ-030 cim_dot4 SHALL be instantiated NCOL times for retirement plus once for the REG_RD forward path.

Verification
REQ-031 Write 0x01020304 to column 0 row 0 (address 0x000), then weight read at address 0x000 -> cim_output=0x01020304 in the same cycle.
REQ-032 Column 0 row 0 = 0x01020304; COMP with act 0x01010101 at row 0, then REG_RD of register 0 in the next cycle (forwarded) -> 10; a second REG_RD one cycle later -> 10.
REQ-033 Column 0 row 0 = 0x80808080, act 0x7F7F7F7F (-128*127*4), 3 back-to-back COMPs -> acc[0] = -195072 = 0xFFFD0600.
REQ-034 COMP immediately followed by CLEAR, then REG_RD -> 0 for all 16 registers.
REQ-035 COMP on row 5 in cycle N and a write of 0 to column 0 row 5 in cycle N+1 -> acc[0] reflects the old weights; a subsequent COMP adds 0.
REQ-036 Assert RES mid-sequence, with a COMP in the same cycle -> all accumulators read 0 after reset and weights are retained.
